// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline register stage with one skid entry, flush squash and flush counter
// Main register drives out_data; the skid register absorbs one extra push so in_ready stays registered.
module pipe_stage_skid #(
  parameter int DATA_W = 139,
  parameter int CTRL_W = 17,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] DATA_KEEP = {{(DATA_W-CTRL_W){1'b1}}, {CTRL_W{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  cnt_q;

  logic push;
  logic pop;
  logic main_load_in;
  logic main_load_skid;
  logic skid_load;

  // Handshake outputs come straight from the state register: no out_ready -> in_ready path.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign flush_cnt = cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // An empty stage presents a bubble: control field reads as a NOP.
  assign out_data = (state == EMPTY) ? (main_q & DATA_KEEP) : main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_next   = ONE;
            main_load_in = 1'b1;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: begin
              state_next   = ONE;
              main_load_in = 1'b1;
            end
            2'b10: begin
              state_next = TWO;
              skid_load  = 1'b1;
            end
            2'b01: state_next = EMPTY;
            default: state_next = ONE;
          endcase
        end
        TWO: begin
          if (pop) begin
            state_next     = ONE;
            main_load_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Flush only squashes the control field; the rest of main is held untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (flush) begin
        main_q[CTRL_W-1:0] <= '0;
      end else if (main_load_in) begin
        main_q <= in_data;
      end else if (main_load_skid) begin
        main_q <= skid_q;
      end
      if (skid_load) begin
        skid_q <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (flush && (state != EMPTY) && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
// A second instance with a 2-bit flush counter shares the stimulus to exercise saturation.
module tb_pipe_stage_skid;

  localparam int DW = 139;
  localparam int CW = 17;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          flush;
  logic [1:0]    occupancy;
  logic [7:0]    flush_cnt;

  logic          in_ready_s;
  logic          out_valid_s;
  logic [DW-1:0] out_data_s;
  logic [1:0]    occupancy_s;
  logic [1:0]    flush_cnt_s;

  int n_tests;
  int n_fail;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .occupancy(occupancy), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready), .flush(flush),
    .occupancy(occupancy_s), .flush_cnt(flush_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] hi, input logic [16:0] lo);
    logic [DW-1:0] d;
    d = '0;
    d[DW-1:DW-32] = hi;
    d[16:0] = lo;
    return d;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #12;
    n_tests++;
    if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: occ=%0d in_ready=%b out_valid=%b expected occ=0 in_ready=1 out_valid=0",
               occupancy, in_ready, out_valid);
    end
    n_tests++;
    if (flush_cnt !== 8'd0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: flush_cnt=%0d out_data=%h expected 0 and 0", flush_cnt, out_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_streaming();
    logic [DW-1:0] vals [3];
    vals[0] = DW'(8'h11); vals[1] = DW'(8'h22); vals[2] = DW'(8'h33);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      step();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b data=%h occ=%0d in_ready=%b expected 1 %h 1 1",
                 i, out_valid, out_data, occupancy, in_ready, vals[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data[CW-1:0] !== '0) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%b occ=%0d ctrl=%h expected 0 0 0",
               out_valid, occupancy, out_data[CW-1:0]);
    end
  endtask

  task automatic test_stall_fill();
    logic [DW-1:0] a1, a2, a3;
    a1 = mk(32'hCAFE_00A1, 17'h0A1);
    a2 = mk(32'hCAFE_00A2, 17'h0A2);
    a3 = mk(32'hCAFE_00A3, 17'h0A3);
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = a1;
    step();
    in_data = a2;
    step();
    n_tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a1) begin
      n_fail++;
      $display("FAIL stall_full: occ=%0d in_ready=%b data=%h expected 2 0 %h", occupancy, in_ready, out_data, a1);
    end
    in_data = a3;
    step();
    n_tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a1) begin
      n_fail++;
      $display("FAIL stall_hold: occ=%0d in_ready=%b data=%h expected 2 0 %h", occupancy, in_ready, out_data, a1);
    end
    out_ready = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== a2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_pop1: valid=%b data=%h occ=%0d in_ready=%b expected 1 %h 1 1",
               out_valid, out_data, occupancy, in_ready, a2);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== a3 || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL stall_pop2: valid=%b data=%h occ=%0d expected 1 %h 1", out_valid, out_data, occupancy, a3);
    end
    in_valid = 1'b0;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_drain: valid=%b occ=%0d expected 0 0 (duplicate emitted)", out_valid, occupancy);
    end
  endtask

  task automatic test_flush_two();
    logic [DW-1:0] b1, b2, b3;
    b1 = mk(32'hDEAD_00B1, 17'h1F0B1);
    b2 = mk(32'hDEAD_00B2, 17'h1F0B2);
    b3 = mk(32'hDEAD_00B3, 17'h1F0B3);
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = b1;
    step();
    in_data = b2;
    step();
    in_data = b3; flush = 1'b1;
    step();
    n_tests++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data[CW-1:0] !== '0) begin
      n_fail++;
      $display("FAIL flush_state: occ=%0d valid=%b ctrl=%h expected 0 0 0", occupancy, out_valid, out_data[CW-1:0]);
    end
    n_tests++;
    if (flush_cnt !== 8'd1 || out_data[DW-1:CW] !== b1[DW-1:CW]) begin
      n_fail++;
      $display("FAIL flush_cnt_hold: cnt=%0d upper=%h expected 1 %h", flush_cnt, out_data[DW-1:CW], b1[DW-1:CW]);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_no_emit: valid=%b occ=%0d expected 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(i + 1);
      step();
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      n_tests++;
      if (flush_cnt_s !== exp_sat[i] || flush_cnt !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL sat_%0d: cnt2=%0d cnt8=%0d expected %0d %0d", i, flush_cnt_s, flush_cnt, exp_sat[i], i + 1);
      end
    end
    in_valid = 1'b1; in_data = DW'(8'h77); flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    n_tests++;
    if (flush_cnt_s !== 2'd3 || flush_cnt !== 8'd5 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_empty_flush: cnt2=%0d cnt8=%0d occ=%0d expected 3 5 0", flush_cnt_s, flush_cnt, occupancy);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] c1;
    c1 = mk(32'h0000_00C1, 17'h0C1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DW'(8'h91);
    step();
    in_data = DW'(8'h92);
    step();
    n_tests++;
    if (occupancy !== 2'd2 || flush_cnt === 8'd0) begin
      n_fail++;
      $display("FAIL areset_pre: occ=%0d cnt=%0d expected 2 and nonzero", occupancy, flush_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (occupancy !== 2'd0 || in_ready !== 1'b1 || flush_cnt !== 8'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: occ=%0d in_ready=%b cnt=%0d valid=%b expected 0 1 0 0",
               occupancy, in_ready, flush_cnt, out_valid);
    end
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = c1; out_ready = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== c1 || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL areset_push: valid=%b data=%h occ=%0d expected 1 %h 1", out_valid, out_data, occupancy, c1);
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush_two();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
